to_lower_stream: RTL

TO_LOWER_STREAM -- requirements
Module: to_lower_stream

---
 rtl/to_lower_stream.sv | 79 +++++++
 1 files changed

// File: rtl/to_lower_stream.sv
// Byte stream to-lower converter with an output FIFO.
// Define TO_LOWER_STREAM_STATS_EN to enable the conv_count statistic.
module to_lower_stream #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic [7:0] conv_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   occ;
  logic          push;
  logic          pop;
  logic          is_upper;
  logic [7:0]    lower;

  assign in_ready  = occ < FULL;
  assign out_valid = occ != '0;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  assign is_upper = (in_data >= 8'h41) &&
                    (in_data <= 8'h5A);
  assign lower    = is_upper ? in_data + 8'h20
                             : in_data;

  // Empty FIFO shows 0x00 rather than a stale entry.
  assign out_data = out_valid ? mem[rptr] : 8'h00;

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      occ  <= '0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      unique case ({push, pop})
        2'b10:   occ <= occ + (AW+1)'(1);
        2'b01:   occ <= occ - (AW+1)'(1);
        default: occ <= occ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push) mem[wptr] <= lower;
  end

`ifdef TO_LOWER_STREAM_STATS_EN
  logic [7:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= 8'h00;
    end else if (push && is_upper &&
                 cnt != 8'hFF) begin
      cnt <= cnt + 8'h01;
    end
  end

  assign conv_count = cnt;
`else
  assign conv_count = 8'h00;
`endif

endmodule
